// File: rtl/spi_mram_responder_if.sv
// spi_mram_responder_if: SPI link between an MRAM controller (master) and the MRAM responder (slave).
interface spi_mram_responder_if;
  logic spiCs_i;
  logic spiClk_i;
  logic spiMosi_i;
  logic spiMiso_o;
  modport master (output spiCs_i, spiClk_i, spiMosi_i, input spiMiso_o);
  modport slave (input spiCs_i, spiClk_i, spiMosi_i, output spiMiso_o);
endinterface

// File: rtl/spi_mram_responder.sv
// spi_mram_responder: oversampled SPI mode-0 slave modelling a serial MRAM (WREN/WRDI/RDSR/READ/WRITE).
// Defining SPI_MRAM_FAST_READ_EN adds FAST_READ (0x0B) with one dummy byte after the address.
module spi_mram_responder #(
  parameter int MEM_AW      = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  spi_mram_responder_if.slave  spi,
  output logic                 wel_o,
  output logic                 busy_o
);
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_RDSR, S_IGNORE, S_RD, S_WR, S_DUMMY} state_t;
  localparam logic [7:0] OP_WREN = 8'h06, OP_WRDI = 8'h04, OP_RDSR = 8'h05, OP_READ = 8'h03, OP_WRITE = 8'h02;
  logic [SYNC_STAGES-1:0] r_cs_s, r_sck_s, r_mosi_s;
  logic r_cs_d, r_sck_d;
  logic w_cs, w_sck, w_bit, w_cs_fall, w_cs_rise, w_rise, w_fall;
  state_t r_state, w_state_nxt, w_rd_state;
  logic [4:0] r_bitcnt;
  logic [6:0] r_shift, r_tx, w_tx_nxt;
  logic [7:0] r_op, w_op, r_rdata, w_src;
  logic [MEM_AW-1:0] r_ptr;
  logic [7:0] r_mem [0:(1<<MEM_AW)-1];
  logic r_extra, r_wel, r_rd_en, r_miso;
  logic w_is_rd, w_byte_done, w_addr_done, w_cnt_clr, w_tx_state;
  logic w_miso_nxt, w_we, w_rd_en_nxt, w_wel_nxt;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      r_cs_s   <= '1;
      r_sck_s  <= '0;
      r_mosi_s <= '0;
      r_cs_d   <= 1'b1;
      r_sck_d  <= 1'b0;
    end else begin
      r_cs_s   <= {r_cs_s[SYNC_STAGES-2:0], spi.spiCs_i};
      r_sck_s  <= {r_sck_s[SYNC_STAGES-2:0], spi.spiClk_i};
      r_mosi_s <= {r_mosi_s[SYNC_STAGES-2:0], spi.spiMosi_i};
      r_cs_d   <= w_cs;
      r_sck_d  <= w_sck;
    end
  assign w_cs      = r_cs_s[SYNC_STAGES-1];
  assign w_sck     = r_sck_s[SYNC_STAGES-1];
  assign w_bit     = r_mosi_s[SYNC_STAGES-1];
  assign w_cs_fall = r_cs_d & ~w_cs;
  assign w_cs_rise = ~r_cs_d & w_cs;
  // gating with synchronized CS makes CS win over a coincident SCK edge
  assign w_rise    = w_sck & ~r_sck_d & ~w_cs;
  assign w_fall    = ~w_sck & r_sck_d & ~w_cs;
  assign w_op        = {r_shift, w_bit};
  assign w_byte_done = w_rise & (r_bitcnt[2:0] == 3'd7);
  assign w_addr_done = w_rise & (r_state == S_ADDR) & (r_bitcnt == 5'd23);
  assign w_cnt_clr   = (r_state == S_ADDR) ? (r_bitcnt == 5'd23) : (r_bitcnt[2:0] == 3'd7);
`ifdef SPI_MRAM_FAST_READ_EN
  assign w_is_rd    = (w_op == OP_READ) || (w_op == 8'h0B);
  assign w_rd_state = (r_op == 8'h0B) ? S_DUMMY : S_RD;
`else
  assign w_is_rd    = w_op == OP_READ;
  assign w_rd_state = S_RD;
`endif
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) r_state <= S_IDLE;
    else r_state <= w_state_nxt;
  always_comb begin
    w_state_nxt = r_state;
    if (w_cs_rise) w_state_nxt = S_IDLE;
    else
      case (r_state)
        S_IDLE:  w_state_nxt = w_cs_fall ? S_CMD : S_IDLE;
        S_CMD:   w_state_nxt = !w_byte_done ? S_CMD : (w_is_rd || w_op == OP_WRITE) ? S_ADDR :
                               (w_op == OP_RDSR) ? S_RDSR : S_IGNORE;
        S_ADDR:  w_state_nxt = !w_addr_done ? S_ADDR : (r_op == OP_WRITE) ? S_WR : w_rd_state;
`ifdef SPI_MRAM_FAST_READ_EN
        S_DUMMY: w_state_nxt = w_byte_done ? S_RD : S_DUMMY;
`endif
        default: w_state_nxt = r_state;
      endcase
  end
  always_comb begin
    w_tx_state  = (r_state == S_RD || r_state == S_RDSR) & ~w_cs;
    w_src       = (r_state == S_RD) ? r_rdata : {6'b0, r_wel, 1'b0};
    w_miso_nxt  = !w_tx_state ? 1'b0 : !w_fall ? r_miso : (r_bitcnt[2:0] == 3'd0) ? w_src[7] : r_tx[6];
    w_tx_nxt    = !w_fall ? r_tx : (r_bitcnt[2:0] == 3'd0) ? w_src[6:0] : {r_tx[5:0], 1'b0};
    w_we        = (r_state == S_WR) & w_byte_done & r_wel;
    w_rd_en_nxt = (w_addr_done & (r_op != OP_WRITE)) | ((r_state == S_RD) & w_byte_done);
    // only a cleanly terminated 8-bit WREN/WRDI lands in IGNORE with no extra clocks
    w_wel_nxt   = !w_cs_rise ? r_wel : (r_op == OP_WRITE) ? 1'b0 :
                  (r_state != S_IGNORE || r_extra) ? r_wel :
                  (r_op == OP_WREN) ? 1'b1 : (r_op == OP_WRDI) ? 1'b0 : r_wel;
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_ptr    <= '0;
      r_op     <= '0;
      r_extra  <= 1'b0;
      r_wel    <= 1'b0;
      r_rd_en  <= 1'b0;
      r_miso   <= 1'b0;
      r_tx     <= '0;
    end else begin
      r_bitcnt <= (w_cs_fall || w_cs_rise) ? '0 : !w_rise ? r_bitcnt : w_cnt_clr ? '0 : r_bitcnt + 5'd1;
      r_shift  <= w_rise ? w_op[6:0] : r_shift;
      r_ptr    <= (w_rise && r_state == S_ADDR) ? {r_ptr[MEM_AW-2:0], w_bit} :
                  (w_byte_done && (r_state == S_RD || r_state == S_WR)) ? r_ptr + MEM_AW'(1) : r_ptr;
      r_op     <= w_cs_fall ? 8'h00 : (r_state == S_CMD && w_byte_done) ? w_op : r_op;
      r_extra  <= w_cs_fall ? 1'b0 : (w_rise && r_state == S_IGNORE) ? 1'b1 : r_extra;
      r_wel    <= w_wel_nxt;
      r_rd_en  <= w_rd_en_nxt;
      r_miso   <= w_miso_nxt;
      r_tx     <= w_tx_nxt;
    end
  always_ff @(posedge clk_i) begin
    if (w_we) r_mem[r_ptr] <= w_op;
    if (r_rd_en) r_rdata <= r_mem[r_ptr];
  end
  assign spi.spiMiso_o = r_miso;
  assign wel_o         = r_wel;
  assign busy_o        = ~w_cs;
endmodule
